// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: operation codes and FSM state values.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SRA = 2'b01,
        OP_SLL = 2'b10,
        OP_ROL = 2'b11
    } op_t;

    // Fixed legacy state encodings kept as plain constants.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// Single-position combinational shift of one word by the selected operation.
// SEQ_SHIFTER_ROTATE_EN enables true rotate for OP_ROL; otherwise OP_ROL acts as SLL.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word,
    input  op_t              op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = word;
        case (op)
            OP_SRL: result = {1'b0, word[WIDTH-1:1]};
            OP_SRA: result = {word[WIDTH-1], word[WIDTH-1:1]};
            OP_SLL: result = {word[WIDTH-2:0], 1'b0};
`ifdef SEQ_SHIFTER_ROTATE_EN
            OP_ROL: result = {word[WIDTH-2:0], word[WIDTH-1]};
`else
            OP_ROL: result = {word[WIDTH-2:0], 1'b0};
`endif
            default: result = word;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock, result published with a one-cycle done pulse.
// Rotate support for op=11 is selected by SEQ_SHIFTER_ROTATE_EN (see shift_step).
module seq_shifter
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [SHW-1:0]   amt,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] stepped;
    op_t              op_q;
    logic [SHW-1:0]   cnt;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .word   (work),
        .op     (op_q),
        .result (stepped)
    );

    assign busy = (state != ST_IDLE);

    // done and dout are loaded on the edge that enters DONE, so they line up with that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            work  <= '0;
            op_q  <= OP_SRL;
            cnt   <= '0;
            done  <= 1'b0;
            dout  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        work <= din;
                        op_q <= op_t'(op);
                        cnt  <= amt;
                        if (amt == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            dout  <= din;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= stepped;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        dout  <= stepped;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter at WIDTH=32.
module tb_seq_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    int checks = 0;
    int errors = 0;

    seq_shifter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .amt   (amt),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one operation, scramble inputs after capture, and observe amt+5 cycles.
    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] d,
                       input logic [4:0] a, input logic [31:0] exp, input bit poke);
        int busy_cnt = 0;
        int done_cnt = 0;
        int first = -1;
        bit early = 1'b0;
        logic [31:0] prev;
        @(negedge clk);
        prev  = dout;
        op    = o;
        din   = d;
        amt   = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~o;
        din   = ~d;
        amt   = ~a;
        for (int i = 0; i <= int'(a) + 4; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (poke && i == 5) begin
                start = 1'b1;
                din   = 32'h0;
                op    = 2'b10;
                amt   = 5'd1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (first < 0) first = i;
            end else if (done_cnt == 0 && dout !== prev) begin
                early = 1'b1;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(first), 32'(a));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(a) + 32'd1);
        check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " dout_early"}, {31'd0, early}, 32'd0);
        check({tag, " dout"}, dout, exp);
    endtask

    initial begin
        int dcount;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        amt   = 5'd0;
        din   = 32'h0;
        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset dout", dout, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run("sra3",  2'b01, 32'hF0F0F0F0, 5'd3,  32'hFE1E1E1E, 1'b0);
        run("srl3",  2'b00, 32'hF0F0F0F0, 5'd3,  32'h1E1E1E1E, 1'b0);
        run("sll3",  2'b10, 32'hF0F0F0F0, 5'd3,  32'h87878780, 1'b0);
        run("amt0",  2'b01, 32'h12345678, 5'd0,  32'h12345678, 1'b0);
        run("amt0r", 2'b11, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0);
        run("sra31", 2'b01, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b1);
        run("srl31", 2'b00, 32'h80000000, 5'd31, 32'h00000001, 1'b0);
`ifdef SEQ_SHIFTER_ROTATE_EN
        run("op11",  2'b11, 32'h80000001, 5'd1,  32'h00000003, 1'b0);
        run("rol4",  2'b11, 32'hF0000000, 5'd4,  32'h0000000F, 1'b0);
`else
        run("op11",  2'b11, 32'h80000001, 5'd1,  32'h00000002, 1'b0);
        run("rol4",  2'b11, 32'hF0000000, 5'd4,  32'h00000000, 1'b0);
`endif

        // Abort an amt=10 operation with reset during its second SHIFT cycle.
        @(negedge clk);
        op    = 2'b00;
        din   = 32'hAAAA5555;
        amt   = 5'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("pre-abort busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort dout", dout, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("abort no done", 32'(dcount), 32'd0);
        check("abort dout hold", dout, 32'h0);

        run("post-rst sll5", 2'b10, 32'h0000FFFF, 5'd5, 32'h001FFFE0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; shift-amount width SHW = $clog2(WIDTH) (5 at default).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 SRL, 01 SRA, 10 SLL, 11 ROL (see Configuration).
REQ-006 amt  input  SHW  shift amount, 0..WIDTH-1.
REQ-007 din  input  WIDTH  operand.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  single-cycle pulse; result valid on dout.
REQ-010 dout  output  WIDTH  result; holds last result until next done.

Function
REQ-011 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-012 IDLE + start=1 at an edge: SHALL capture din into the working register, op into the op register, amt into counter cnt; go to SHIFT if amt!=0, else DONE.
REQ-013 SHIFT, each edge: working register SHALL shift one position per the latched op, cnt decrements by 1; when cnt==1 before the edge, next state SHALL be DONE.
REQ-014 SRL SHALL fill MSB with 0; SRA SHALL replicate the sign bit (bit WIDTH-1); SLL SHALL fill LSB with 0; ROL SHALL move bit WIDTH-1 into bit 0.
REQ-015 DONE SHALL last exactly one cycle with done=1 and dout=working register, then return to IDLE.
REQ-016 Latency: done SHALL be high in the cycle after edge (start edge + max(amt,0) + 1), i.e. amt+1 cycles after the capturing edge.
REQ-017 start, op, amt, din SHALL be ignored while busy=1, including during DONE; a new start is accepted only in IDLE (back-to-back spacing >= amt+2 cycles).
REQ-018 dout SHALL be registered and update only in the cycle done is asserted; it SHALL NOT reflect intermediate shift values.
REQ-019 Inputs changing after the capturing edge SHALL NOT affect the result.

Reset
REQ-020 rst=1 SHALL force, asynchronously: state IDLE, busy=0, done=0, dout=0, cnt=0, working register=0.
REQ-021 rst asserted mid-operation SHALL abort it with no done pulse; first start after rst deasserts SHALL behave as from power-up.

Configuration
REQ-022 Macro SEQ_SHIFTER_ROTATE_EN: when defined, op=11 SHALL perform ROL.
REQ-023 When SEQ_SHIFTER_ROTATE_EN is undefined, op=11 SHALL behave exactly as SLL and no rotate logic SHALL be synthesized.

Structure
REQ-024 Package shift_pkg SHALL hold the op encoding typedef (OP_SRL, OP_SRA, OP_SLL, OP_ROL) and FSM state typedef.
REQ-025 Single-position shift SHALL be a combinational sub-module shift_step (inputs word, op; output word) instantiated once.

Verification
REQ-026 SRA, din=0xF0F0F0F0, amt=3 -> done 4 cycles after start edge, dout=0xFE1E1E1E.
REQ-027 SRL and SLL, din=0xF0F0F0F0, amt=3 -> dout=0x1E1E1E1E and 0x87878780 respectively, busy high 4 cycles each.
REQ-028 amt=0, din=0x12345678, any op -> done in cycle after start edge, dout=0x12345678.
REQ-029 SRA, din=0x80000000, amt=31 -> done after 32 cycles, dout=0xFFFFFFFF; a start pulsed mid-operation is ignored.
REQ-030 rst asserted at SHIFT cycle 2 of amt=10 -> busy=0, done=0, dout=0 immediately, no done pulse follows.
REQ-031 op=11, din=0x80000001, amt=1 -> dout=0x00000003 with SEQ_SHIFTER_ROTATE_EN, 0x00000002 without.
